// File: rtl/sar_adc_sequencer_if.sv
// Purpose: bundles the control, comparator, CDAC and result handshake signals of the SAR ADC sequencer.
// Latency: none, wiring only.
// Backpressure: result_valid/result_ack handshake; the producer never stalls, and an unacknowledged result is overwritten and flagged.
//
// Port summary (signal names follow the analog macro / tt_um wrapper naming):
//   inputs to sequencer  : ena, start, scan_mode, ch_sel[2:0], ch_mask[NCH-1:0], cmp_in, result_ack
//   outputs of sequencer : mux_sel[2:0], sample_en, dac_code[NBITS-1:0], busy,
//                          result_valid, result[NBITS-1:0], result_ch[2:0], overrun
//   modport slave  : the sequencer side
//   modport master : the wrapper / bench side
interface sar_adc_sequencer_if #(
  parameter int NBITS = 8,
  parameter int NCH   = 6
);
  logic             ena;
  logic             start;
  logic             scan_mode;
  logic [2:0]       ch_sel;
  logic [NCH-1:0]   ch_mask;
  logic             cmp_in;
  logic             result_ack;
  logic [2:0]       mux_sel;
  logic             sample_en;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             result_valid;
  logic [NBITS-1:0] result;
  logic [2:0]       result_ch;
  logic             overrun;

  modport slave (
    input  ena, start, scan_mode, ch_sel, ch_mask, cmp_in, result_ack,
    output mux_sel, sample_en, dac_code, busy, result_valid, result, result_ch, overrun
  );

  modport master (
    output ena, start, scan_mode, ch_sel, ch_mask, cmp_in, result_ack,
    input  mux_sel, sample_en, dac_code, busy, result_valid, result, result_ch, overrun
  );
endinterface

// File: rtl/sar_adc_sequencer.sv
// Purpose: SAR ADC controller; it drives the analog mux, times track-and-hold, and binary-searches the CDAC code from comparator decisions.
// Latency: result_valid rises 1 + SETTLE_CYCLES*(NBITS+1) + SAMPLE_CYCLES edges after the accepting edge (32 with defaults).
// Backpressure: none upstream; a result left unacknowledged at the next DONE is overwritten and sets the sticky overrun flag.
//
// Ports:
//   clk   : system clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : sar_adc_sequencer_if.slave (control inputs, comparator, CDAC/mux drive, result handshake)
// Optional build macro SAR_ADC_SEQUENCER_CONTINUOUS_EN:
//   when defined, a scan wraps from the highest masked channel back to the lowest and keeps converting
//   until a start pulse while busy (stop request; the current channel completes) or ena low.
// Parameter limits: SETTLE_CYCLES >= 3 (covers the 2-flop comparator synchronizer), SAMPLE_CYCLES >= 1, NCH <= 8.
module sar_adc_sequencer #(
  parameter int NBITS         = 8,
  parameter int NCH           = 6,
  parameter int SETTLE_CYCLES = 3,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_adc_sequencer_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  // The counter runs from (length-1) down to 0, so CNT_MAX-1 must fit.
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    SAMPLE_LD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [BW-1:0]    MSB_IDX   = BW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_ONLY  = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [3:0]       NCH_LIM   = 4'(NCH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX,
    S_SAMPLE,
    S_BIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [2:0]       mux_q, mux_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic             scan_q, scan_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [2:0]       rch_q, rch_d;
  logic             rvld_q, rvld_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, sync2_q;
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
  logic             stop_q, stop_d;
`endif

  logic             start_legal;
  logic             stop_now;
  logic [NBITS-1:0] bit_oh;
  logic [NBITS-1:0] kept;
  logic [3:0]       nxt_ch;

  // Index of the lowest set bit of m (0 when m is empty; callers guarantee m != 0).
  function automatic logic [2:0] lowest_set(input logic [NCH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit of m strictly above channel cur.
  function automatic logic [3:0] next_set(input logic [NCH-1:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k] && (k > int'(cur))) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  always_comb begin
    start_legal = bus.scan_mode ? (|bus.ch_mask) : ({1'b0, bus.ch_sel} < NCH_LIM);
    bit_oh      = NBITS'(1) << bit_q;
    // Decision for the bit under trial: comparator high keeps it, low drops it.
    kept        = sync2_q ? dac_q : (dac_q & ~bit_oh);
    nxt_ch      = next_set(mask_q, mux_q);
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
    stop_now    = stop_q | (bus.ena & bus.start);
`else
    stop_now    = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    mux_d   = mux_q;
    mask_d  = mask_q;
    scan_d  = scan_q;
    dac_d   = dac_q;
    res_d   = res_q;
    rch_d   = rch_q;
    rvld_d  = rvld_q;
    ovr_d   = ovr_q;
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
    stop_d  = stop_q;
    if (state_q == S_IDLE) begin
      stop_d = 1'b0;
    end else if (bus.ena && bus.start) begin
      stop_d = 1'b1;
    end
`endif

    // The consumer may acknowledge in any state, including during an abort.
    if (rvld_q && bus.result_ack) begin
      rvld_d = 1'b0;
    end

    if ((state_q != S_IDLE) && !bus.ena) begin
      // Abort: drop the partial conversion and leave the published result untouched.
      state_d = S_IDLE;
      dac_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ena && bus.start && start_legal) begin
            state_d = S_MUX;
            cnt_d   = SETTLE_LD;
            mux_d   = bus.scan_mode ? lowest_set(bus.ch_mask) : bus.ch_sel;
            mask_d  = bus.ch_mask;
            scan_d  = bus.scan_mode;
            ovr_d   = 1'b0;
            dac_d   = '0;
          end
        end

        S_MUX: begin
          if (cnt_q == '0) begin
            state_d = S_SAMPLE;
            cnt_d   = SAMPLE_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_SAMPLE: begin
          if (cnt_q == '0) begin
            state_d = S_BIT;
            cnt_d   = SETTLE_LD;
            bit_d   = MSB_IDX;
            dac_d   = MSB_ONLY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_BIT: begin
          // The synchronized comparator is only trusted on the last cycle of the window.
          if (cnt_q == '0) begin
            if (bit_q == '0) begin
              state_d = S_DONE;
              dac_d   = kept;
            end else begin
              cnt_d = SETTLE_LD;
              bit_d = bit_q - 1'b1;
              dac_d = kept | (bit_oh >> 1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          res_d  = dac_q;
          rch_d  = mux_q;
          rvld_d = 1'b1;
          // A same-cycle ack retires the old result, so only an unacked one counts as lost.
          if (rvld_q && !bus.result_ack) begin
            ovr_d = 1'b1;
          end
          dac_d = '0;
          if (scan_q && nxt_ch[3] && !stop_now) begin
            state_d = S_MUX;
            cnt_d   = SETTLE_LD;
            mux_d   = nxt_ch[2:0];
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
          end else if (scan_q && !stop_now) begin
            state_d = S_MUX;
            cnt_d   = SETTLE_LD;
            mux_d   = lowest_set(mask_q);
`endif
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          dac_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      mux_q   <= '0;
      mask_q  <= '0;
      scan_q  <= 1'b0;
      dac_q   <= '0;
      res_q   <= '0;
      rch_q   <= '0;
      rvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      mux_q   <= mux_d;
      mask_q  <= mask_d;
      scan_q  <= scan_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      rch_q   <= rch_d;
      rvld_q  <= rvld_d;
      ovr_q   <= ovr_d;
      sync1_q <= bus.cmp_in;
      sync2_q <= sync1_q;
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
      stop_q  <= stop_d;
`endif
    end
  end

  assign bus.mux_sel      = mux_q;
  assign bus.sample_en    = (state_q == S_SAMPLE);
  assign bus.dac_code     = dac_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result_valid = rvld_q;
  assign bus.result       = res_q;
  assign bus.result_ch    = rch_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Purpose: self-checking bench for sar_adc_sequencer with an ideal comparator driven from per-channel input voltages.
// Latency: expected timing comes from the conversion schedule (MUX settle, sample, NBITS trials, DONE).
// Backpressure: acks are issued at random delays, or withheld to exercise overrun.
module tb_sar_adc_sequencer;
  localparam int NB  = 8;
  localparam int NC  = 6;
  localparam int SET = 3;
  localparam int SMP = 4;
  localparam int LAT = 1 + SET * (NB + 1) + SMP;
`ifdef SAR_ADC_SEQUENCER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] vin_tab [8];

  sar_adc_sequencer_if #(.NBITS(NB), .NCH(NC)) bus();

  sar_adc_sequencer #(
    .NBITS(NB), .NCH(NC), .SETTLE_CYCLES(SET), .SAMPLE_CYCLES(SMP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Ideal comparator: high when the selected channel's input is at or above the DAC level.
  always_comb bus.cmp_in = (vin_tab[bus.mux_sel] >= bus.dac_code);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Binary search against an ideal comparator: trial k has vin's bits above
  // position b=NB-1-k already resolved and tries bit b set.
  function automatic logic [31:0] trial(input logic [7:0] vin, input int k);
    int b;
    int hi;
    b  = NB - 1 - k;
    hi = int'(vin) & ~((1 << (b + 1)) - 1) & 255;
    return 32'(hi | (1 << b));
  endfunction

  task automatic do_start(input bit scan, input logic [2:0] ch, input logic [5:0] mask);
    bus.scan_mode = scan;
    bus.ch_sel    = ch;
    bus.ch_mask   = mask;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic ack_clear();
    if (bus.result_valid) begin
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
    end
  endtask

  // Observes one channel conversion, starting on the cycle after its MUX entry
  // (n=0) and ending at n=LAT. ack_at >= 0 acks the previous result at that
  // cycle; -1 means no result is pending; -2 means pending and deliberately unacked.
  task automatic window(input logic [2:0] ch, input logic [7:0] vin, input int ack_at,
                        input bit pulse, input string tag);
    int sp_cnt = 0;
    int sp_first = -1;
    int terr = 0;
    int early = 0;
    chk({tag, "_mux"}, 32'(bus.mux_sel), 32'(ch));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (ack_at == 0) bus.result_ack = 1'b1;
    for (int n = 1; n <= LAT; n++) begin
      tick();
      if (ack_at >= 0 && n == ack_at + 1) begin
        bus.result_ack = 1'b0;
        chk({tag, "_ackclr"}, 32'(bus.result_valid), 32'd0);
      end
      if (ack_at >= 1 && n == ack_at) bus.result_ack = 1'b1;
      if (n == 10) begin
        if (pulse) bus.start = 1'b1;
        bus.ch_sel  = 3'($urandom_range(0, 7));
        bus.ch_mask = 6'($urandom);
      end
      if (n == 11) bus.start = 1'b0;
      if (bus.sample_en) begin
        sp_cnt++;
        if (sp_first < 0) sp_first = n;
      end
      if (n < LAT && bus.result_valid && (ack_at == -1 || (ack_at >= 0 && n > ack_at))) early++;
      for (int k = 0; k < NB; k++) begin
        if (n == SET + SMP + SET * k && 32'(bus.dac_code) !== trial(vin, k)) terr++;
      end
      if (n == LAT - 1 && bus.dac_code !== vin) terr++;
    end
    chk({tag, "_trials"}, 32'(terr), 32'd0);
    chk({tag, "_smpcnt"}, 32'(sp_cnt), 32'(SMP));
    chk({tag, "_smpfirst"}, 32'(sp_first), 32'(SET));
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.result), 32'(vin));
    chk({tag, "_rch"}, 32'(bus.result_ch), 32'(ch));
    chk({tag, "_dac0"}, 32'(bus.dac_code), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_smp"}, 32'(bus.sample_en), 32'd0);
    chk({tag, "_dac"}, 32'(bus.dac_code), 32'd0);
    chk({tag, "_mux"}, 32'(bus.mux_sel), 32'd0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_res"}, 32'(bus.result), 32'd0);
    chk({tag, "_rch"}, 32'(bus.result_ch), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    logic [2:0] ch;
    logic [7:0] v;
    bus.ena        = 1'b1;
    bus.start      = 1'b0;
    bus.scan_mode  = 1'b0;
    bus.ch_sel     = '0;
    bus.ch_mask    = '0;
    bus.result_ack = 1'b0;
    for (int i = 0; i < 8; i++) vin_tab[i] = 8'h00;

    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // Single conversion, directed mid-scale code.
    vin_tab[2] = 8'hA5;
    do_start(1'b0, 3'd2, 6'h00);
    window(3'd2, 8'hA5, -1, 1'b1, "s_a5");
    chk("s_a5_idle", 32'(bus.busy), 32'd0);
    ack_clear();

    // Boundary codes.
    vin_tab[0] = 8'h00;
    do_start(1'b0, 3'd0, 6'h00);
    window(3'd0, 8'h00, -1, 1'b1, "s_00");
    ack_clear();
    vin_tab[5] = 8'hFF;
    do_start(1'b0, 3'd5, 6'h00);
    window(3'd5, 8'hFF, -1, 1'b1, "s_ff");
    ack_clear();

    // Random single conversions.
    repeat (4) begin
      ch = 3'($urandom_range(0, NC - 1));
      v  = 8'($urandom);
      vin_tab[ch] = v;
      do_start(1'b0, ch, 6'h00);
      window(ch, v, -1, 1'b1, "s_rnd");
      ack_clear();
    end

    // Masked scan with prompt acks.
    vin_tab[0] = 8'h10;
    vin_tab[2] = 8'h7F;
    vin_tab[5] = 8'hE3;
    do_start(1'b1, 3'd0, 6'b100101);
    window(3'd0, 8'h10, -1, !CONT, "sc0");
    chk("sc0_ovr", 32'(bus.overrun), 32'd0);
    window(3'd2, 8'h7F, int'($urandom_range(0, 4)), !CONT, "sc2");
    chk("sc2_ovr", 32'(bus.overrun), 32'd0);
    window(3'd5, 8'hE3, int'($urandom_range(0, 4)), 1'b1, "sc5");
    chk("sc_idle", 32'(bus.busy), 32'd0);
    chk("sc_ovr", 32'(bus.overrun), 32'd0);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk("sc_lastack", 32'(bus.result_valid), 32'd0);

    // Same scan without acks: second DONE overwrites and flags overrun.
    do_start(1'b1, 3'd0, 6'b100101);
    window(3'd0, 8'h10, -1, !CONT, "no0");
    chk("no0_ovr", 32'(bus.overrun), 32'd0);
    window(3'd2, 8'h7F, -2, !CONT, "no2");
    chk("no2_ovr", 32'(bus.overrun), 32'd1);
    window(3'd5, 8'hE3, -2, 1'b1, "no5");
    chk("no5_ovr", 32'(bus.overrun), 32'd1);
    chk("no_idle", 32'(bus.busy), 32'd0);

    // Next accepted start clears overrun; then abort with ena low.
    vin_tab[1] = 8'h3C;
    do_start(1'b0, 3'd1, 6'h00);
    chk("ovr_clr", 32'(bus.overrun), 32'd0);
    repeat (10) tick();
    bus.ena = 1'b0;
    tick();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_smp", 32'(bus.sample_en), 32'd0);
    chk("abort_dac", 32'(bus.dac_code), 32'd0);
    chk("abort_rv", 32'(bus.result_valid), 32'd1);
    chk("abort_res", 32'(bus.result), 32'hE3);
    chk("abort_ovr", 32'(bus.overrun), 32'd0);
    bus.ena = 1'b1;
    tick();

    // Illegal / disabled starts are ignored.
    do_start(1'b1, 3'd0, 6'b000000);
    chk("ill_mask", 32'(bus.busy), 32'd0);
    do_start(1'b0, 3'd6, 6'h00);
    chk("ill_ch", 32'(bus.busy), 32'd0);
    bus.ena = 1'b0;
    do_start(1'b0, 3'd1, 6'h00);
    chk("ill_ena", 32'(bus.busy), 32'd0);
    bus.ena = 1'b1;

    // Reset mid-conversion while an old result is still valid.
    vin_tab[3] = 8'($urandom);
    do_start(1'b0, 3'd3, 6'h00);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_state("midrst");
    rst_n = 1'b1;
    tick();

    // Two-channel scan: one pass by default, wrap until stop when continuous.
    vin_tab[0] = 8'($urandom);
    vin_tab[1] = 8'($urandom);
    do_start(1'b1, 3'd0, 6'b000011);
    window(3'd0, vin_tab[0], -1, 1'b0, "w0");
    if (CONT) begin
      window(3'd1, vin_tab[1], int'($urandom_range(0, 4)), 1'b0, "w1");
      window(3'd0, vin_tab[0], int'($urandom_range(0, 4)), 1'b0, "wrap0");
    end
    window(3'd1, vin_tab[1], int'($urandom_range(0, 4)), 1'b1, "w1end");
    chk("w_idle", 32'(bus.busy), 32'd0);
    chk("w_ovr", 32'(bus.overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sar_adc_sequencer.md
Name: sar_adc_sequencer

Overview:
- Digital controller for the on-chip successive-approximation ADC built around the analog pins ua[5:0].
- Per conversion it:
  - drives the analog input mux select;
  - times the track-and-hold sample switch;
  - steps the capacitive-DAC trial code bit by bit from the external comparator's decisions;
  - publishes each result with a valid/ack handshake.
- Supports single-channel conversion and a masked one-pass scan across channels.
- Sits between the top-level tt_um wrapper I/O (ui_in/uio) and the analog macro.

Parameters:
- NBITS, 8, conversion resolution and dac_code/result width.
- NCH, 6, number of analog channels (max 8).
- SETTLE_CYCLES, 3, cycles per mux settle and per bit trial; includes the 2-flop comparator synchronizer delay; must be >= 3.
- SAMPLE_CYCLES, 4, cycles sample_en is held high; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  enable; low aborts any conversion
- start  in  1  one-cycle start request
- scan_mode  in  1  0 = single channel ch_sel, 1 = scan ch_mask
- ch_sel  in  3  channel for single mode
- ch_mask  in  NCH  channel mask for scan mode
- cmp_in  in  1  asynchronous comparator output; 1 means Vin >= DAC
- result_ack  in  1  consumer acknowledges result
- mux_sel  out  3  analog mux select
- sample_en  out  1  track-and-hold switch enable
- dac_code  out  NBITS  CDAC trial code
- busy  out  1  sequencer not in IDLE
- result_valid  out  1  result holding register full
- result  out  NBITS  converted code
- result_ch  out  3  channel of result
- overrun  out  1  sticky: an unacknowledged result was overwritten

Behaviour:
- Clock and reset: all state updates on rising clk. rst_n low at an edge resets the block regardless of state.
- Reset values:
  - state = IDLE;
  - mux_sel, dac_code, result, result_ch = 0;
  - sample_en, busy, result_valid, overrun = 0;
  - synchronizer flops = 0.
- Synchronizer: cmp_in passes through a 2-flop synchronizer. Each bit decision uses the synchronized value on the last cycle of that bit's settle window.
- State IDLE:
  - start is accepted when ena=1 and the request is legal:
    - single mode: ch_sel < NCH;
    - scan mode: ch_mask != 0.
  - An illegal start is ignored.
  - On acceptance:
    - mux_sel is loaded (ch_sel, or the lowest set mask bit);
    - the mask is latched;
    - overrun is cleared;
    - the next state is MUX.
- State MUX: runs SETTLE_CYCLES cycles with sample_en=0 and dac_code=0.
- State SAMPLE: runs SAMPLE_CYCLES cycles with sample_en=1 and dac_code=0.
- State BIT: bit index i runs from NBITS-1 down to 0.
  - On entry to each i: dac_code = kept | (1<<i).
  - Held for SETTLE_CYCLES cycles.
  - On the last cycle: synced cmp=1 keeps bit i, cmp=0 clears it.
  - After i=0, the next state is DONE.
- State DONE (1 cycle):
  - result = final code; result_ch = mux_sel; result_valid = 1.
  - Then dac_code = 0.
  - Scan mode: go to MUX with mux_sel = next higher set bit of the latched mask; otherwise go to IDLE.
  - Single mode: go to IDLE.
- Latency: result_valid rises at edge E0 + 1 + SETTLE_CYCLES*(NBITS+1) + SAMPLE_CYCLES, where E0 is the start-accepting edge. With defaults this is E0+32. Per-channel period in scan mode is 32 cycles.
- busy = (state != IDLE). busy goes 1 the cycle after acceptance and returns to 0 the cycle after the final DONE.
- Result handshake:
  - result_ack while result_valid clears result_valid at the next edge.
  - At DONE with result_valid=1 and no same-cycle ack: the result is overwritten and overrun is set (sticky until the next accepted start or reset).
  - At DONE with a same-cycle ack: the new result is valid and overrun is unchanged.
- start while busy is ignored; the mask and channel are not re-latched.
- ena low in any non-IDLE state:
  - next edge returns to IDLE;
  - sample_en = 0, dac_code = 0;
  - result, result_valid and overrun are unchanged; no partial result is published.
- ch_mask and ch_sel changes during a conversion have no effect.

Optional Feature:
- Macro: SAR_ADC_SEQUENCER_CONTINUOUS_EN.
- Defined: in scan mode, after the DONE of the highest masked channel, the block wraps to the lowest masked channel and continues indefinitely.
  - Stop conditions: a start pulse while busy (stop request) or ena low.
  - On a stop request, the block finishes the current channel's DONE, then goes to IDLE.
- Not defined: a scan is a single pass; start while busy is ignored.

Test Plan:
- Single mode, ch_sel=2, ideal comparator model cmp_in=(vin>=dac_code) with vin=0xA5, start at E0 -> mux_sel=2; sample_en high for 4 cycles; result_valid at E0+32; result=0xA5, result_ch=2, busy low next cycle.
- Boundary codes vin=0x00 and vin=0xFF -> results 0x00 and 0xFF; dac_code trial sequence for 0xFF is 0x80, 0xC0, ..., 0xFF.
- Scan, ch_mask=6'b100101, per-channel vin {ch0:0x10, ch2:0x7F, ch5:0xE3}, ack each result within 5 cycles -> three results in order ch0, ch2, ch5 at E0+32/64/96; overrun=0; IDLE after.
- Same scan with no ack -> result=0xE3, result_ch=5, overrun=1 after the second DONE; next accepted start clears overrun.
- ena low at E0+10 -> IDLE at E0+11, sample_en=0, dac_code=0, result_valid unchanged; start with ch_mask=0 in scan mode -> busy stays 0.
- rst_n low mid-conversion -> all outputs at reset values after the edge; with CONTINUOUS_EN defined, 2-channel scan wraps back to the first channel until a stop start pulse.
